// File: rtl/radix4_mult_sequencer.sv
// Operand sequencer for a radix-4 online multiplier: feeds digit pairs MSD first,
// then collects no_of_digits+1 product digits from the multiplier output stream.
module radix4_mult_sequencer #(
  parameter int no_of_digits = 4,
  parameter int radix_bits   = 3,
  parameter int delta        = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [no_of_digits*radix_bits-1:0]    din1,
  input  logic [no_of_digits*radix_bits-1:0]    din2,
  output logic [radix_bits-1:0]                 x,
  output logic [radix_bits-1:0]                 y,
  input  logic [radix_bits-1:0]                 z,
  output logic                                  mul_clear,
  output logic                                  full_result_sel,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [(no_of_digits+1)*radix_bits-1:0] dout
);

  localparam int OpW     = no_of_digits * radix_bits;
  localparam int DoutW   = (no_of_digits + 1) * radix_bits;
  localparam int RunLen  = no_of_digits + delta;
  localparam int CntW    = (RunLen > 1) ? $clog2(RunLen) : 1;
  localparam logic [CntW-1:0] LastCnt  = CntW'(RunLen - 1);
  localparam logic [CntW-1:0] CapStart = CntW'(delta - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [OpW-1:0]    opa_q, opa_d;
  logic [OpW-1:0]    opb_q, opb_d;
  logic [radix_bits-1:0] x_q, x_d;
  logic [radix_bits-1:0] y_q, y_d;
  logic              clr_q, clr_d;
  logic [DoutW-1:0]  dout_q, dout_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      clr_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      x_q     <= x_d;
      y_q     <= y_d;
      clr_q   <= clr_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    dout_d  = dout_q;
    x_d     = '0;
    y_d     = '0;
    clr_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          opa_d   = din1;
          opb_d   = din2;
          dout_d  = '0;
          clr_d   = 1'b1;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        // The multiplier's first delta-1 outputs are pipeline fill, not product digits
        if (cnt_q >= CapStart) begin
          dout_d = {dout_q[DoutW-radix_bits-1:0], z};
        end
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Digits are registered, so select the one for the cycle about to start
    if (state_d == RUN) begin
      for (int i = 0; i < no_of_digits; i++) begin
        if (cnt_d == CntW'(i)) begin
          x_d = opa_q[(no_of_digits-1-i)*radix_bits +: radix_bits];
          y_d = opb_q[(no_of_digits-1-i)*radix_bits +: radix_bits];
        end
      end
    end
  end

  assign in_ready        = (state_q == IDLE);
  assign out_valid       = (state_q == DONE);
  assign full_result_sel = 1'b1;
  assign x               = x_q;
  assign y               = y_q;
  assign mul_clear       = clr_q;
  assign dout            = dout_q;

endmodule

// File: tb/tb_radix4_mult_sequencer.sv
// Directed bench for radix4_mult_sequencer with a stub multiplier: either z = cycle+1
// after clear, or z = running mod-8 sum of the x+y digits fed since clear.
module tb_radix4_mult_sequencer;

  localparam int N  = 4;
  localparam int R  = 3;
  localparam int D  = 2;
  localparam int W  = N * R;
  localparam int DW = (N + 1) * R;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  din1, din2;
  logic [R-1:0]  x, y, z;
  logic          mul_clear;
  logic          full_result_sel;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] dout;

  int checkCount = 0;
  int failCount  = 0;
  int clearPulses = 0;

  bit       stubMode = 1'b0;
  logic [2:0] stubCnt, stubAcc;

  always #5 clk = ~clk;

  radix4_mult_sequencer #(.no_of_digits(N), .radix_bits(R), .delta(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .din1(din1), .din2(din2), .x(x), .y(y), .z(z),
    .mul_clear(mul_clear), .full_result_sel(full_result_sel),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout)
  );

  // Stub multiplier restarts on mul_clear like the real one would
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stubCnt <= 3'd0;
      stubAcc <= 3'd0;
    end else if (mul_clear) begin
      stubCnt <= 3'd0;
      stubAcc <= 3'd0;
    end else begin
      stubCnt <= stubCnt + 3'd1;
      stubAcc <= stubAcc + x + y;
    end
  end

  assign z = stubMode ? stubAcc : (stubCnt + 3'd1);

  always @(posedge clk) begin
    if (mul_clear) clearPulses <= clearPulses + 1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1, "[TB] timeout");
  end

  // Expected dout for the accumulating stub
  function automatic logic [DW-1:0] modelDout(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2:0]    s;
    logic [DW-1:0] d;
    s = 3'd0;
    d = '0;
    for (int c = 0; c < N + D; c++) begin
      if (c >= D - 1) d = {d[DW-R-1:0], s};
      if (c < N) s = s + a[(N-1-c)*R +: R] + b[(N-1-c)*R +: R];
    end
    return d;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents a pair and returns just after the accepting edge (DUT in CLEAR)
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input bit holdValid, output int waits);
    din1     = a;
    din2     = b;
    in_valid = 1'b1;
    waits    = 0;
    while (!in_ready && waits < 50) begin
      @(posedge clk); #1;
      waits++;
    end
    checkOutput("accept_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    if (!holdValid) in_valid = 1'b0;
  endtask

  task automatic waitResult(input string tag, input logic [DW-1:0] exp, output int lat);
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({tag, "_valid"}, 64'(out_valid), 64'(1));
    checkOutput({tag, "_dout"}, 64'(dout), 64'(exp));
  endtask

  initial begin
    int waits, lat, base, seen;
    logic [R-1:0] expDigit [6];
    logic [W-1:0] ra, rb;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; din1 = '0; din2 = '0;
    #12;
    checkOutput("rst_in_ready", 64'(in_ready), 64'(1));
    checkOutput("rst_full_sel", 64'(full_result_sel), 64'(1));
    checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_mul_clear", 64'(mul_clear), 64'(0));
    checkOutput("rst_x", 64'(x), 64'(0));
    checkOutput("rst_y", 64'(y), 64'(0));
    checkOutput("rst_dout", 64'(dout), 64'(0));
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("post_rst_in_ready", 64'(in_ready), 64'(1));
    checkOutput("post_rst_full_sel", 64'(full_result_sel), 64'(1));

    // Counting stub, operands 1,2,3,4 in both lanes
    $display("[TB] counting stub, 12'o1234 x 12'o1234");
    stubMode = 1'b0;
    applyStimulus(12'o1234, 12'o1234, 1'b0, waits);
    checkOutput("clear_pulse", 64'(mul_clear), 64'(1));
    checkOutput("clear_x", 64'(x), 64'(0));
    checkOutput("clear_y", 64'(y), 64'(0));
    checkOutput("clear_in_ready", 64'(in_ready), 64'(0));
    expDigit = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd0};
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("run%0d_x", k), 64'(x), 64'(expDigit[k]));
      checkOutput($sformatf("run%0d_y", k), 64'(y), 64'(expDigit[k]));
      checkOutput($sformatf("run%0d_clear", k), 64'(mul_clear), 64'(0));
      checkOutput($sformatf("run%0d_out_valid", k), 64'(out_valid), 64'(0));
    end
    @(posedge clk); #1;
    checkOutput("latency7_out_valid", 64'(out_valid), 64'(1));
    checkOutput("count_dout", 64'(dout), 64'(15'o23456));
    checkOutput("done_x", 64'(x), 64'(0));

    // Backpressure: DONE holds while in_valid pulses are ignored
    for (int k = 0; k < 10; k++) begin
      in_valid = k[0];
      din1 = 12'o7070; din2 = 12'o0707;
      @(posedge clk); #1;
      checkOutput($sformatf("bp%0d_dout", k), 64'(dout), 64'(15'o23456));
      checkOutput($sformatf("bp%0d_in_ready", k), 64'(in_ready), 64'(0));
      checkOutput($sformatf("bp%0d_out_valid", k), 64'(out_valid), 64'(1));
    end

    // Release with in_valid high: the exit edge must not accept
    stubMode = 1'b1;
    din1 = 12'o1000; din2 = 12'o1000; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("exit_in_ready", 64'(in_ready), 64'(1));
    checkOutput("exit_out_valid", 64'(out_valid), 64'(0));
    base = clearPulses;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("q_clear_pulse", 64'(mul_clear), 64'(1));
    checkOutput("q_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    checkOutput("q_first_digit_x", 64'(x), 64'(1));
    checkOutput("q_clear_low", 64'(mul_clear), 64'(0));
    waitResult("quarter", 15'o22222, lat);
    checkOutput("quarter_clear_count", 64'(clearPulses - base), 64'(1));

    // Directed with wrap-around in the accumulating stub
    applyStimulus(12'o7777, 12'o0001, 1'b0, waits);
    waitResult("wrap", 15'o76555, lat);
    checkOutput("wrap_latency", 64'(lat), 64'(7));

    // Reset at RUN cnt=2 abandons the operation
    applyStimulus(12'o1234, 12'o4321, 1'b0, waits);
    repeat (3) begin @(posedge clk); #1; end
    checkOutput("mid_run_x", 64'(x), 64'(3));
    checkOutput("mid_run_y", 64'(y), 64'(2));
    rst = 1'b1;
    #1;
    checkOutput("arst_x", 64'(x), 64'(0));
    checkOutput("arst_y", 64'(y), 64'(0));
    checkOutput("arst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("arst_in_ready", 64'(in_ready), 64'(1));
    checkOutput("arst_dout", 64'(dout), 64'(0));
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checkOutput("arst_no_out_valid", 64'(seen), 64'(0));
    applyStimulus(12'o1000, 12'o1000, 1'b0, waits);
    waitResult("after_rst", 15'o22222, lat);

    // Back-to-back random pairs, in_valid and out_ready held high
    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      applyStimulus(ra, rb, 1'b1, waits);
      if (i > 0) checkOutput($sformatf("b2b%0d_idle_gap", i), 64'(waits), 64'(1));
      waitResult($sformatf("b2b%0d", i), modelDout(ra, rb), lat);
      checkOutput($sformatf("b2b%0d_latency", i), 64'(lat), 64'(7));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("final_idle", 64'(in_ready), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
